// File: rtl/wshb_pkg.sv
// Shared types for the Wishbone framebuffer responder: cycle-type tags, burst-type
// constant and the responder FSM state encoding.
package wshb_pkg;

  typedef enum logic [2:0] {
    CTI_CLASSIC = 3'b000,
    CTI_INCR    = 3'b010,
    CTI_EOB     = 3'b111
  } cti_e;

  localparam logic [1:0] BTE_LINEAR = 2'b00;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StAck,
    StBurst
  } fsm_e;

endpackage

// File: rtl/fb_ram.sv
// Single-port framebuffer word RAM with per-byte write enables and a registered read port.
module fb_ram #(
  parameter int unsigned AW = 17
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  input  logic [3:0]    be,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  localparam int unsigned Words = 1 << AW;

  logic [31:0] mem [Words];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/wshb_fb_responder.sv
// Wishbone B4 slave in front of the framebuffer RAM: classic and incrementing-burst cycles,
// programmable wait states before the first ack, err on misaligned/out-of-range accesses.
module wshb_fb_responder
  import wshb_pkg::*;
#(
  parameter int unsigned DEPTH_WIDTH = 17,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cyc,
  input  logic        stb,
  input  logic        we,
  input  logic [31:0] adr,
  input  logic [3:0]  sel,
  input  logic [31:0] dat_ms,
  input  logic [2:0]  cti,
  input  logic [1:0]  bte,
  output logic [31:0] dat_sm,
  output logic        ack,
  output logic        err,
  output logic        rty
);

  localparam int unsigned AW = DEPTH_WIDTH;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  fsm_e          state_q, state_d;
  logic [AW:0]   wadr_q, wadr_d, wadr_inc;
  logic          err_q, err_d;
  logic [3:0]    wait_q, wait_d;

  logic          req, beat, req_err, ram_wr;
  logic [AW-1:0] ram_addr;
  logic [3:0]    ram_be;
  logic [31:0]   rdata;

  assign req      = cyc & stb;
  assign req_err  = (adr[1:0] != 2'b00) | (|adr[31:AW+2]) | (bte != BTE_LINEAR);
  assign wadr_inc = wadr_q + {{AW{1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      wadr_q  <= '0;
      err_q   <= 1'b0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wadr_q  <= wadr_d;
      err_q   <= err_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wadr_d  = wadr_q;
    err_d   = err_q;
    wait_d  = wait_q;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          wadr_d = {1'b0, adr[AW+1:2]};
          err_d  = req_err;
          if (WAIT_STATES == 0) begin
            state_d = StAck;
          end else begin
            state_d = StWait;
            wait_d  = WAIT_INIT;
          end
        end
      end
      StWait: begin
        if (!req) begin
          state_d = StIdle;
        end else begin
          wait_d = wait_q - 4'd1;
          if (wait_q == 4'd1) state_d = StAck;
        end
      end
      StAck: begin
        if (req && !err_q && cti == CTI_INCR) begin
          state_d = StBurst;
          wadr_d  = wadr_inc;
          err_d   = wadr_inc[AW];
        end else begin
          state_d = StIdle;
        end
      end
      StBurst: begin
        if (!cyc) begin
          state_d = StIdle;
        end else if (stb) begin
          if (err_q || cti != CTI_INCR) begin
            state_d = StIdle;
          end else begin
            // Top bit of the widened address flags a beat past the end of the RAM.
            wadr_d = wadr_inc;
            err_d  = wadr_inc[AW];
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    beat   = req & ((state_q == StAck) | (state_q == StBurst));
    ack    = beat & ~err_q;
    err    = beat & err_q;
    rty    = 1'b0;
    dat_sm = ack ? rdata : '0;
    ram_wr = ack & we;
    // Writes use the current beat address; otherwise prefetch the next beat's word.
    ram_addr = ram_wr ? wadr_q[AW-1:0] : wadr_d[AW-1:0];
    ram_be   = ram_wr ? sel : 4'b0000;
  end

  fb_ram #(
    .AW(AW)
  ) u_ram (
    .clk  (clk),
    .addr (ram_addr),
    .be   (ram_be),
    .wdata(dat_ms),
    .rdata(rdata)
  );

endmodule
